// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H sprite from a synchronous ROM into
// the palette-index frame buffer, skipping transparent pixels and clipping at
// the frame edges.
module sprite_blitter #(
    parameter int unsigned FB_WIDTH        = 320,
    parameter int unsigned FB_HEIGHT       = 240,
    parameter int unsigned SPR_W           = 16,
    parameter int unsigned SPR_H           = 16,
    parameter logic [7:0]  TRANSPARENT_IDX = 8'hFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [8:0]  sprite_x,
    input  logic [7:0]  sprite_y,
    input  logic [15:0] rom_base,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [18:0] write_address,
    output logic [7:0]  data_In,
    output logic        we,
    output logic        busy,
    output logic        done
);

    localparam int unsigned N_PIX = SPR_W * SPR_H;
    localparam int unsigned KW    = $clog2(N_PIX);
    localparam int unsigned CW    = $clog2(SPR_W);
    localparam int unsigned RW    = $clog2(SPR_H);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN1,
        DRAIN2,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            busy_next;
    logic            done_next;
    logic            load;
    logic            step;

    logic [KW-1:0]   k;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [8:0]      x_lat;
    logic [7:0]      y_lat;
    logic            last_k;

    logic [CW-1:0]   col_d;
    logic [RW-1:0]   row_d;
    logic            valid_d;
    logic [9:0]      px;
    logic [8:0]      py;
    logic [18:0]     pix_addr;
    logic            wr_ok;

    assign last_k = (k == KW'(N_PIX - 1));

    // State register plus the registered busy/done flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_k) begin
                    state_next = DRAIN1;
                end
            end
            DRAIN1: state_next = DRAIN2;
            DRAIN2: begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Origin latch, ROM address stepping and pixel column/row counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_lat    <= '0;
            y_lat    <= '0;
            rom_addr <= '0;
            k        <= '0;
            col      <= '0;
            row      <= '0;
        end else if (load) begin
            x_lat    <= sprite_x;
            y_lat    <= sprite_y;
            rom_addr <= rom_base;
            k        <= '0;
            col      <= '0;
            row      <= '0;
        end else if (step && !last_k) begin
            k        <= k + KW'(1);
            rom_addr <= rom_addr + 16'd1;
            if (col == CW'(SPR_W - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Delay col/row/valid by one cycle so they line up with rom_data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            col_d   <= '0;
            row_d   <= '0;
            valid_d <= 1'b0;
        end else begin
            col_d   <= col;
            row_d   <= row;
            valid_d <= (state == RUN);
        end
    end

    // Screen position, clip/transparency test and linear frame address
    always_comb begin
        px       = 10'(x_lat) + 10'(col_d);
        py       = 9'(y_lat) + 9'(row_d);
        pix_addr = 19'(py) * 19'(FB_WIDTH) + 19'(px);
        wr_ok    = valid_d && (px < 10'(FB_WIDTH)) && (py < 9'(FB_HEIGHT))
                   && (rom_data != TRANSPARENT_IDX);
    end

    // Registered write port; address and data hold when no write is issued
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we            <= 1'b0;
            write_address <= '0;
            data_In       <= '0;
        end else begin
            we <= wr_ok;
            if (wr_ok) begin
                write_address <= pix_addr;
                data_In       <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed scenarios plus randomized
// blits, each compared cycle by cycle against a pixel-level reference model.
module tb_sprite_blitter;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [8:0]  sprite_x;
    logic [7:0]  sprite_y;
    logic [15:0] rom_base;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] write_address;
    logic [7:0]  data_In;
    logic        we;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rom_mem [0:65535];
    logic        exp_we   [0:300];
    logic [18:0] exp_addr [0:300];
    logic [7:0]  exp_data [0:300];
    int          exp_count;

    sprite_blitter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .rom_base     (rom_base),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .write_address(write_address),
        .data_In      (data_In),
        .we           (we),
        .busy         (busy),
        .done         (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: one cycle of read latency
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected write schedule: pixel k lands on the write port in cycle 3+k
    function automatic void build_model(input int x, input int y, input logic [15:0] base);
        logic [15:0] a;
        logic [7:0]  d;
        int px, py;
        exp_count = 0;
        for (int i = 0; i <= 300; i++) begin
            exp_we[i]   = 1'b0;
            exp_addr[i] = '0;
            exp_data[i] = '0;
        end
        for (int k = 0; k < 256; k++) begin
            px = x + (k % 16);
            py = y + (k / 16);
            a  = base + 16'(k);
            d  = rom_mem[a];
            if (px < 320 && py < 240 && d != 8'hFF) begin
                exp_we[3 + k]   = 1'b1;
                exp_addr[3 + k] = 19'(py * 320 + px);
                exp_data[3 + k] = d;
                exp_count++;
            end
        end
    endfunction

    task automatic launch(input int x, input int y, input logic [15:0] base);
        @(negedge Clk);
        sprite_x = 9'(x);
        sprite_y = 8'(y);
        rom_base = base;
        start    = 1'b1;
        @(posedge Clk);
    endtask

    // Called right after the accepting edge; mode 1 re-pulses start while busy
    task automatic monitor(input int x, input int y, input logic [15:0] base,
                           input int ncyc, input int mode,
                           output int nw, output int first_a, output int last_a);
        logic [15:0] ea;
        build_model(x, y, base);
        nw      = 0;
        first_a = -1;
        last_a  = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Clk);
            if (c == 1) start = 1'b0;
            ea = (c <= 256) ? base + 16'(c - 1) : base + 16'd255;
            check($sformatf("busy c=%0d", c), 32'(busy), 32'(c <= 258));
            check($sformatf("done c=%0d", c), 32'(done), 32'(c == 259));
            check($sformatf("rom_addr c=%0d", c), 32'(rom_addr), 32'(ea));
            check($sformatf("we c=%0d", c), 32'(we), 32'(exp_we[c]));
            if (exp_we[c]) begin
                check($sformatf("write_address c=%0d", c), 32'(write_address), 32'(exp_addr[c]));
                check($sformatf("data_In c=%0d", c), 32'(data_In), 32'(exp_data[c]));
            end
            if (we === 1'b1) begin
                nw++;
                if (first_a < 0) first_a = int'(write_address);
                last_a = int'(write_address);
                check($sformatf("addr_range c=%0d", c), 32'(write_address < 19'd76800), 32'd1);
            end
            if (mode == 1) begin
                if (c == 50) begin
                    start    = 1'b1;
                    sprite_x = 9'd100;
                    sprite_y = 8'd50;
                    rom_base = 16'h1000;
                end
                if (c == 51)  start = 1'b0;
                if (c == 259) start = 1'b1;
            end
        end
        check("write_count", 32'(nw), 32'(exp_count));
    endtask

    task automatic blit(input int x, input int y, input logic [15:0] base,
                        output int nw, output int first_a, output int last_a);
        launch(x, y, base);
        monitor(x, y, base, 262, 0, nw, first_a, last_a);
    endtask

    task automatic fill(input logic [15:0] base, input int pat);
        logic [15:0] a;
        for (int k = 0; k < 256; k++) begin
            a = base + 16'(k);
            case (pat)
                0: rom_mem[a] = (k == 255) ? 8'h00 : 8'(k);
                1: rom_mem[a] = (k == 5) ? 8'h2A : 8'hFF;
                2: rom_mem[a] = 8'h11;
                3: rom_mem[a] = 8'(k * 3 + 1);
                default: rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            endcase
        end
    endtask

    initial begin
        int nw, fa, la;
        int rx, ry;
        logic [15:0] rb;

        Reset    = 1'b1;
        start    = 1'b0;
        sprite_x = '0;
        sprite_y = '0;
        rom_base = '0;
        for (int i = 0; i < 65536; i++) rom_mem[i] = 8'hFF;

        #3;
        check("rst rom_addr", 32'(rom_addr), 32'd0);
        check("rst write_address", 32'(write_address), 32'd0);
        check("rst data_In", 32'(data_In), 32'd0);
        check("rst we", 32'(we), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Basic copy
        fill(16'h0000, 0);
        blit(0, 0, 16'h0000, nw, fa, la);
        check("basic count", 32'(nw), 32'd256);
        check("basic first", 32'(fa), 32'd0);
        check("basic last", 32'(la), 32'd4815);

        // Transparency
        fill(16'h0000, 1);
        blit(10, 20, 16'h0000, nw, fa, la);
        check("transp count", 32'(nw), 32'd1);
        check("transp addr", 32'(fa), 32'd6415);

        // Clipping at the bottom-right corner
        fill(16'h0000, 2);
        blit(312, 232, 16'h0000, nw, fa, la);
        check("clip count", 32'(nw), 32'd64);
        check("clip first", 32'(fa), 32'd74552);
        check("clip last", 32'(la), 32'd76799);

        // Fully off-screen, ROM address wrapping past 16'hFFFF
        fill(16'hFFC0, 2);
        blit(400, 10, 16'hFFC0, nw, fa, la);
        check("offscreen count", 32'(nw), 32'd0);

        // Start while busy and in the done cycle, then back-to-back blit
        fill(16'h0000, 0);
        fill(16'h1000, 3);
        launch(0, 0, 16'h0000);
        monitor(0, 0, 16'h0000, 260, 1, nw, fa, la);
        check("busy-start count", 32'(nw), 32'd256);
        @(posedge Clk);
        monitor(100, 50, 16'h1000, 262, 0, nw, fa, la);
        check("second blit first", 32'(fa), 32'd16100);

        // Reset mid-blit
        launch(0, 0, 16'h0000);
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clk);
            if (c == 1) start = 1'b0;
        end
        check("pre-reset we", 32'(we), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("mid-reset we", 32'(we), 32'd0);
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset done", 32'(done), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 280; c++) begin
            @(negedge Clk);
            check($sformatf("post-reset we c=%0d", c), 32'(we), 32'd0);
            check($sformatf("post-reset done c=%0d", c), 32'(done), 32'd0);
        end
        blit(0, 0, 16'h0000, nw, fa, la);
        check("after-reset count", 32'(nw), 32'd256);

        // Randomized blits
        for (int t = 0; t < 6; t++) begin
            rx = $urandom_range(0, 335);
            ry = $urandom_range(0, 250);
            rb = 16'($urandom);
            fill(rb, 4);
            blit(rx, ry, rb, nw, fa, la);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
